// File: rtl/echo_pkg.sv
// rtl/echo_pkg.sv - shared glyph table, segment indices and width helper for echo_scan
package echo_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Hex glyphs 0..F, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/echo_scan_if.sv
// rtl/echo_scan_if.sv - control inputs and display outputs of echo_scan
interface echo_scan_if #(
    parameter int DIGITS = 4
);
    import echo_pkg::*;

    localparam int CW = clog2(DIGITS + 1);

    logic              RE;
    logic              LD;
    logic              CLR;
    logic [3:0]        E;
    logic              LZB;
    logic [DIGITS-1:0] AN;
    logic [6:0]        SEG;
    logic [CW-1:0]     CNT;
    logic              OVF;

    modport master (
        output RE, LD, CLR, E, LZB,
        input  AN, SEG, CNT, OVF
    );

    modport slave (
        input  RE, LD, CLR, E, LZB,
        output AN, SEG, CNT, OVF
    );

endinterface

// File: rtl/echo_seg7.sv
// rtl/echo_seg7.sv - combinational 4-bit code to seven-segment glyph decoder
module echo_seg7
    import echo_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    logic [6:0] glyph;

    assign glyph = GLYPH[code];

    // Pin order on the board connector is fixed as {a,b,c,d,e,f,g}
    assign seg = {glyph[SEG_A], glyph[SEG_B], glyph[SEG_C], glyph[SEG_D],
                  glyph[SEG_E], glyph[SEG_F], glyph[SEG_G]};

endmodule

// File: rtl/echo_scan.sv
// rtl/echo_scan.sv - shift-register digit store driving a multiplexed seven-segment display
module echo_scan
    import echo_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic        CLK,
    input  logic        RS,
    echo_scan_if.slave  bus
);

    localparam int CW = clog2(DIGITS + 1);
    localparam int PW = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
    localparam int IW = clog2(DIGITS);

    logic [3:0]        d [DIGITS];
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic [PW-1:0]     p;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] zero_from;
    logic              acc;
    logic              blank;
    logic              load;
    logic [6:0]        glyph;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    assign load = bus.LD && bus.RE && !bus.CLR;

    always_ff @(posedge CLK or posedge RS) begin
        if (RS) begin
            for (int i = 0; i < DIGITS; i++) begin
                d[i] <= 4'h0;
            end
            cnt <= '0;
            ovf <= 1'b0;
        end else if (bus.CLR) begin
            for (int i = 0; i < DIGITS; i++) begin
                d[i] <= 4'h0;
            end
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                d[i] <= d[i-1];
            end
            d[0] <= bus.E;
            if (cnt == CW'(DIGITS)) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Prescaler and scan index free-run regardless of enable and clear
    always_ff @(posedge CLK or posedge RS) begin
        if (RS) begin
            p   <= '0;
            idx <= '0;
        end else if (p == PW'(SCAN_DIV - 1)) begin
            p   <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            p <= p + 1'b1;
        end
    end

    // zero_from[i] is set when digits i and above are all zero
    always_comb begin
        zero_from = '0;
        acc       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (d[i] == 4'h0);
            zero_from[i] = acc;
        end
    end

    assign blank = bus.LZB && (idx != '0) && zero_from[idx];

    echo_seg7 u_seg7 (
        .code (d[idx]),
        .seg  (glyph)
    );

    always_ff @(posedge CLK or posedge RS) begin
        if (RS) begin
            an_q  <= '0;
            seg_q <= '0;
        end else if (!bus.RE) begin
            an_q  <= '0;
            seg_q <= '0;
        end else begin
            an_q  <= DIGITS'(1) << idx;
            seg_q <= blank ? 7'h00 : glyph;
        end
    end

    assign bus.AN  = an_q;
    assign bus.SEG = seg_q;
    assign bus.CNT = cnt;
    assign bus.OVF = ovf;

endmodule

// File: tb/tb_echo_scan.sv
// tb/tb_echo_scan.sv - scoreboard bench for echo_scan against a digit-list reference model
module tb_echo_scan;

    localparam int ND = 4;
    localparam int SD = 4;

    logic clk;
    logic rs;

    echo_scan_if #(.DIGITS(ND)) bus ();

    echo_scan #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
        .CLK (clk),
        .RS  (rs),
        .bus (bus)
    );

    typedef struct {
        int an;
        int seg;
        int cnt;
        int ovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    int glyph_tab [16] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70,
                           'h7F, 'h7B, 'h77, 'h1F, 'h4E, 'h3D, 'h4F, 'h47};

    // Reference state: m_dig[0] is the rightmost digit, m_tick counts edges since reset
    int m_dig [ND];
    int m_cnt;
    int m_ovf;
    int m_tick;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: computes the display from the pre-edge state, then applies the edge
    initial begin
        exp_t x;
        int   ix;
        bit   blk;
        forever begin
            @(posedge clk or posedge rs);
            if (rs) begin
                for (int i = 0; i < ND; i++) m_dig[i] = 0;
                m_cnt  = 0;
                m_ovf  = 0;
                m_tick = 0;
            end else begin
                ix  = (m_tick / SD) % ND;
                blk = 0;
                if (bus.LZB && ix >= 1) begin
                    blk = 1;
                    for (int j = ix; j < ND; j++) if (m_dig[j] != 0) blk = 0;
                end
                x.an  = bus.RE ? (1 << ix) : 0;
                x.seg = (bus.RE && !blk) ? glyph_tab[m_dig[ix]] : 0;
                if (bus.CLR) begin
                    for (int i = 0; i < ND; i++) m_dig[i] = 0;
                    m_cnt = 0;
                    m_ovf = 0;
                end else if (bus.LD && bus.RE) begin
                    if (m_cnt == ND) m_ovf = 1;
                    for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                    m_dig[0] = int'(bus.E);
                    m_cnt = (m_cnt < ND) ? m_cnt + 1 : ND;
                end
                x.cnt = m_cnt;
                x.ovf = m_ovf;
                m_tick++;
                sb.push_back(x);
            end
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (!rs) begin
                    check("an",  int'(bus.AN),  x.an);
                    check("seg", int'(bus.SEG), x.seg);
                    check("cnt", int'(bus.CNT), x.cnt);
                    check("ovf", int'(bus.OVF), x.ovf);
                    check("an_onehot", ($countones(bus.AN) <= 1) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic step(input logic ld, input logic [3:0] e, input logic clr,
                        input logic re, input logic lzb);
        bus.LD  = ld;
        bus.E   = e;
        bus.CLR = clr;
        bus.RE  = re;
        bus.LZB = lzb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        rs      = 1'b1;
        bus.LD  = 1'b0;
        bus.E   = 4'h0;
        bus.CLR = 1'b0;
        bus.RE  = 1'b1;
        bus.LZB = 1'b0;
        #2;
        check("rst_an",  int'(bus.AN),  0);
        check("rst_seg", int'(bus.SEG), 0);
        check("rst_cnt", int'(bus.CNT), 0);
        check("rst_ovf", int'(bus.OVF), 0);
        @(negedge clk);
        rs = 1'b0;

        // Idle scan: first edge after reset shows digit 0 with glyph 0
        step(0, 4'h0, 0, 1, 0);
        check("first_an",  int'(bus.AN),  1);
        check("first_seg", int'(bus.SEG), 'h7E);
        repeat (16) step(0, 4'h0, 0, 1, 0);

        // Three loads with leading-zero blanking
        step(1, 4'h1, 0, 1, 1);
        step(1, 4'h2, 0, 1, 1);
        step(1, 4'h3, 0, 1, 1);
        check("cnt_three", int'(bus.CNT), 3);
        repeat (16) step(0, 4'h0, 0, 1, 1);

        // Five loads overflow the store
        for (int k = 0; k < 5; k++) step(1, 4'(4'hA + k), 0, 1, 0);
        check("cnt_sat", int'(bus.CNT), 4);
        check("ovf_set", int'(bus.OVF), 1);
        repeat (16) step(0, 4'h0, 0, 1, 0);

        // Clear wins over a simultaneous load
        step(1, 4'h7, 1, 1, 0);
        check("clr_cnt", int'(bus.CNT), 0);
        check("clr_ovf", int'(bus.OVF), 0);
        repeat (4) step(0, 4'h0, 0, 1, 0);

        // Disabled display ignores loads while scanning continues
        step(1, 4'h5, 0, 1, 0);
        repeat (3) step(1, 4'h9, 0, 0, 0);
        check("dis_an",  int'(bus.AN),  0);
        check("dis_cnt", int'(bus.CNT), 1);
        repeat (12) step(0, 4'h0, 0, 1, 0);

        // Reset mid-frame while digit 2 is selected and three digits are held
        step(0, 4'h0, 1, 1, 0);
        step(1, 4'h4, 0, 1, 0);
        step(1, 4'h5, 0, 1, 0);
        step(1, 4'h6, 0, 1, 0);
        guard = 0;
        while (((m_tick / SD) % ND) != 2 && guard < 32) begin
            step(0, 4'h0, 0, 1, 0);
            guard++;
        end
        check("reach_idx2", (guard < 32) ? 1 : 0, 1);
        check("pre_rs_cnt", int'(bus.CNT), 3);
        #2;
        rs = 1'b1;
        #1;
        check("async_an",  int'(bus.AN),  0);
        check("async_seg", int'(bus.SEG), 0);
        check("async_cnt", int'(bus.CNT), 0);
        @(posedge clk);
        #1;
        rs = 1'b0;
        step(0, 4'h0, 0, 1, 0);
        check("restart_an", int'(bus.AN), 1);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)));
        end
        step(0, 4'h0, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_scan.md
# echo_scan

Parametrised, clocked successor to the single-digit code-to-seven-segment decoder. It accepts 4-bit codes one at a time into a calculator-style shift register of DIGITS digits and drives a time-multiplexed common-segment display. It adds enable/blank, optional leading-zero blanking, a digit count and a sticky overflow flag. It sits between the keypad/input logic and the board display pins.

## Interface
- DIGITS, default 4: number of display digits; legal range 2..8.
- SCAN_DIV, default 1000: CLK cycles each digit stays selected; legal minimum 1.
- CW: derived, clog2(DIGITS+1); width of CNT.
- CLK  in  1  single clock; all state updates on its rising edge.
- RS  in  1  reset, asynchronous, active-high.
- RE  in  1  enable: 1 = display and loads active; 0 = outputs blanked and LD ignored.
- LD  in  1  load strobe, one digit per cycle it is high.
- CLR  in  1  synchronous clear of digits, CNT and OVF.
- E  in  4  code to load (0x0..0xF).
- LZB  in  1  leading-zero blanking enable.
- AN  out  DIGITS  one-hot digit select, active-high; bit 0 = rightmost digit.
- SEG  out  7  segments {a,b,c,d,e,f,g}; SEG[6] = a; active-high.
- CNT  out  CW  digits entered since clear; saturates at DIGITS.
- OVF  out  1  sticky: a digit was shifted out of the top.

## Operation
- Digit store: DIGITS × 4-bit registers D[0..DIGITS-1].
- Load: when LD=1 and RE=1 and CLR=0 at an edge:
  - D[i] <= D[i-1] for i ≥ 1, and D[0] <= E.
  - CNT increments, saturating at DIGITS.
  - If CNT == DIGITS before the load, OVF <= 1.
- CLR=1 at an edge: all D, CNT and OVF go to 0. CLR acts regardless of RE and wins over a simultaneous LD.
- Scan prescaler P counts 0..SCAN_DIV-1, then wraps. When P == SCAN_DIV-1, the scan index I advances (I+1) mod DIGITS. I wraps from DIGITS-1 to 0.
- P and I free-run whatever the values of RE, LD and CLR.
- Glyphs: standard hex 0-F. Lower-case b and d; 6 with segment a lit; 7 = a,b,c; 9 with segment d lit.
- Leading-zero blanking: with LZB=1, digit I (I ≥ 1) is blank if D[I..DIGITS-1] are all zero. Digit 0 is never blank.
- Output register, updated every edge:
  - RE=0: AN=0, SEG=0.
  - RE=1, digit blank: AN=onehot(I), SEG=0.
  - Otherwise: AN=onehot(I), SEG=glyph(D[I]).

## Timing
- Reset state, all asynchronous on RS:
  - D=0, CNT=0, OVF=0, P=0, I=0.
  - AN=0, SEG=0.
- First edge after RS falls: AN=0b…0001 (with RE=1), SEG=glyph(0)=0x7E.
- Latency of 1 cycle for each of these to reach AN/SEG: LD, CLR, RE, LZB and I changes.
- Each digit is shown for exactly SCAN_DIV cycles; a full frame is DIGITS×SCAN_DIV cycles.
- SCAN_DIV=1: I advances every cycle.
- AN has at most one bit set at all times, including across RE toggles and reset.
- Back-to-back LD accepted every cycle; there is no handshake and no backpressure.
- RS mid-frame returns to the reset state immediately; scanning restarts at digit 0.

## Structure
- Package echo_pkg:
  - 16-entry glyph constant table.
  - Segment bit-index constants (SEG_A..SEG_G).
  - clog2 function.
- Sub-module echo_seg7: purely combinational 4-bit → 7-bit glyph decoder using the package table. It is instantiated once, on the muxed digit.
- Top echo_scan contains:
  - digit shift register with CNT/OVF logic;
  - prescaler and scan index;
  - leading-zero compare;
  - output register.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4.
- Reset, then RE=1 and idle: AN cycles 0001, 0010, 0100, 1000, each for 4 cycles. SEG=0x7E throughout; CNT=0, OVF=0.
- LD with E=1, 2, 3 on consecutive cycles: D = {0,1,2,3} (D[3]..D[0]), CNT=3. With LZB=1, AN=1000 shows SEG=0. The other digits show 3 (0x79), 2 (0x6D) and 1 (0x30) on AN=0001, 0010 and 0100.
- 5 loads E=A..E: CNT=4 and OVF=1 after the 5th load. D = {B,C,D,E}; digit 3 shows b (0x1F).
- CLR and LD high in the same cycle after the previous scenario: D=0, CNT=0, OVF=0, and the LD is ignored.
- RE=0 for 3 cycles during the scan: AN=0 and SEG=0 one cycle later; LD pulses are ignored (CNT unchanged). The scan index keeps advancing, and on RE=1 the display resumes at the correct digit.
- RS asserted mid-frame with I=2 and CNT=3: AN=0, SEG=0 and CNT=0 asynchronously (before the next edge). After release, the display restarts at AN=0001.
